// File: rtl/gumnut_bus_pkg.sv
// ----------------------------------------------------------------------------
// gumnut_bus_pkg
// Shared types and constants for the Gumnut data-bus arbiter.
//   arb_state_t : arbiter FSM state encoding
//   M0 / M1     : master index values used for gnt_idx / last_idx
// ----------------------------------------------------------------------------
package gumnut_bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GNT,
        ARB_ERR
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage : gumnut_bus_pkg

// File: rtl/gumnut_bus_arbiter_rr_pick2.sv
// ----------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin pick.
//   req[1:0] : request vector (bit 0 = m0, bit 1 = m1)
//   last_idx : most recently granted master
//   valid    : at least one request present
//   idx      : chosen master; on a tie the one that was not granted last
// ----------------------------------------------------------------------------
module rr_pick2
    import gumnut_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_idx,
    output logic       valid,
    output logic       idx
);

    always_comb begin
        valid = |req;
        if (req == 2'b11) begin
            idx = ~last_idx;
        end else if (req[1]) begin
            idx = M1;
        end else begin
            idx = M0;
        end
    end

endmodule : rr_pick2

// File: rtl/gumnut_bus_arbiter.sv
// ----------------------------------------------------------------------------
// gumnut_bus_arbiter
// Round-robin arbiter sharing one Wishbone-style data-memory slave between
// the Gumnut core data bus (m0) and a secondary master (m1). The grant is
// held for a whole bus cycle; a watchdog reports a one-cycle bus error to
// the granted master when the slave stops acknowledging.
//
// Ports
//   clk, rst_n                    : clock, async active-low reset
//   mX_cyc_i/stb_i/we_i/adr_i/dat_i : master X request side
//   mX_dat_o/ack_o/err_o          : master X response side
//   s_cyc_o/stb_o/we_o/adr_o/dat_o  : slave request side
//   s_dat_i, s_ack_i              : slave response side
//   gnt_o                         : one-hot registered grant, 00 = idle
//
// State      | meaning
// -----------+---------------------------------------------------------
// ARB_IDLE   | no grant, arbitrate every edge
// ARB_GNT    | master r_gnt_idx owns the slave, watchdog running
// ARB_ERR    | one-cycle error report to r_gnt_idx, slave strobe gated
// ----------------------------------------------------------------------------
module gumnut_bus_arbiter
    import gumnut_bus_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_adr_i,
    input  logic [DATA_W-1:0] m0_dat_i,
    output logic [DATA_W-1:0] m0_dat_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,

    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_adr_i,
    input  logic [DATA_W-1:0] m1_dat_i,
    output logic [DATA_W-1:0] m1_dat_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,

    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [ADDR_W-1:0] s_adr_o,
    output logic [DATA_W-1:0] s_dat_o,
    input  logic [DATA_W-1:0] s_dat_i,
    input  logic              s_ack_i,

    output logic [1:0]        gnt_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT - 1);

    arb_state_t       r_state;
    logic             r_gnt_idx;
    logic             r_last_idx;
    logic [CNT_W-1:0] r_wd_cnt;

    arb_state_t       w_state_nxt;
    logic             w_gnt_idx_nxt;
    logic             w_last_idx_nxt;
    logic [CNT_W-1:0] w_wd_cnt_nxt;
    logic             w_rearb;

    logic              w_cyc;
    logic              w_stb;
    logic              w_we;
    logic [ADDR_W-1:0] w_adr;
    logic [DATA_W-1:0] w_dat;

    logic w_pick_valid;
    logic w_pick_idx;

    // Granted master's request bundle
    assign w_cyc = (r_gnt_idx == M1) ? m1_cyc_i : m0_cyc_i;
    assign w_stb = (r_gnt_idx == M1) ? m1_stb_i : m0_stb_i;
    assign w_we  = (r_gnt_idx == M1) ? m1_we_i  : m0_we_i;
    assign w_adr = (r_gnt_idx == M1) ? m1_adr_i : m0_adr_i;
    assign w_dat = (r_gnt_idx == M1) ? m1_dat_i : m0_dat_i;

    // One picker serves both idle arbitration and release handover; on
    // release the owner's cyc is already low so it cannot re-win.
    rr_pick2 u_pick (
        .req      ({m1_cyc_i, m0_cyc_i}),
        .last_idx (r_last_idx),
        .valid    (w_pick_valid),
        .idx      (w_pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ARB_IDLE;
            r_gnt_idx  <= M0;
            r_last_idx <= M1;
            r_wd_cnt   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt_idx  <= w_gnt_idx_nxt;
            r_last_idx <= w_last_idx_nxt;
            r_wd_cnt   <= w_wd_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_idx_nxt  = r_gnt_idx;
        w_last_idx_nxt = r_last_idx;
        w_wd_cnt_nxt   = '0;
        w_rearb        = 1'b0;

        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;

        case (r_state)
            ARB_IDLE: begin
                w_rearb = 1'b1;
            end
            ARB_GNT: begin
                s_cyc_o  = w_cyc;
                s_stb_o  = w_stb;
                s_we_o   = w_we;
                s_adr_o  = w_adr;
                s_dat_o  = w_dat;
                m0_ack_o = s_ack_i && (r_gnt_idx == M0);
                m1_ack_o = s_ack_i && (r_gnt_idx == M1);
                if (!w_cyc) begin
                    w_rearb = 1'b1;
                end else if (w_stb && !s_ack_i) begin
                    // An ack on the limit cycle skips this branch, so ack wins.
                    if (r_wd_cnt == WD_LIMIT) begin
                        w_state_nxt = ARB_ERR;
                    end else begin
                        w_wd_cnt_nxt = r_wd_cnt + 1'b1;
                    end
                end
            end
            ARB_ERR: begin
                m0_err_o = (r_gnt_idx == M0);
                m1_err_o = (r_gnt_idx == M1);
                if (!w_cyc) begin
                    w_rearb = 1'b1;
                end else begin
                    w_state_nxt = ARB_GNT;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase

        if (w_rearb) begin
            if (w_pick_valid) begin
                w_state_nxt    = ARB_GNT;
                w_gnt_idx_nxt  = w_pick_idx;
                w_last_idx_nxt = w_pick_idx;
            end else begin
                w_state_nxt    = ARB_IDLE;
            end
        end
    end

    assign gnt_o = (r_state == ARB_IDLE) ? 2'b00 :
                   (r_gnt_idx == M1)     ? 2'b10 : 2'b01;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule : gumnut_bus_arbiter

// File: tb/tb_gumnut_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_gumnut_bus_arbiter
// Directed scenarios followed by randomized traffic. A reference model that
// tracks owner / last winner / unacked-strobe run length predicts every
// output on each falling edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gumnut_bus_arbiter;

    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] cyc, stb, we;
    logic [7:0] adr [2];
    logic [7:0] dat [2];
    logic [7:0] s_dat;
    logic       s_ack;

    logic [7:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
    logic       m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic       s_cyc_o, s_stb_o, s_we_o;
    logic [1:0] gnt_o;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int m_owner = -1;
    int m_last  = 1;
    bit m_err   = 1'b0;
    int m_run   = 0;

    gumnut_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0_cyc_i (cyc[0]),
        .m0_stb_i (stb[0]),
        .m0_we_i  (we[0]),
        .m0_adr_i (adr[0]),
        .m0_dat_i (dat[0]),
        .m0_dat_o (m0_dat_o),
        .m0_ack_o (m0_ack_o),
        .m0_err_o (m0_err_o),
        .m1_cyc_i (cyc[1]),
        .m1_stb_i (stb[1]),
        .m1_we_i  (we[1]),
        .m1_adr_i (adr[1]),
        .m1_dat_i (dat[1]),
        .m1_dat_o (m1_dat_o),
        .m1_ack_o (m1_ack_o),
        .m1_err_o (m1_err_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_dat_i  (s_dat),
        .s_ack_i  (s_ack),
        .gnt_o    (gnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input bit c0, input bit c1, input int last);
        if (c0 && c1) return 1 - last;
        if (c0)       return 0;
        if (c1)       return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 1;
        m_err   = 1'b0;
        m_run   = 0;
    endtask

    task automatic model_step();
        int p;
        if (m_owner < 0 || !cyc[m_owner]) begin
            p       = pick(cyc[0], cyc[1], m_last);
            m_owner = p;
            m_err   = 1'b0;
            m_run   = 0;
            if (p >= 0) m_last = p;
        end else if (m_err) begin
            m_err = 1'b0;
            m_run = 0;
        end else if (stb[m_owner] && !s_ack) begin
            m_run++;
            if (m_run == TO) begin
                m_err = 1'b1;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic check_outputs();
        logic [1:0]  e_gnt;
        logic [18:0] e_s;
        logic [9:0]  e_m0, e_m1;
        bit          busy;
        busy  = (m_owner >= 0) && !m_err;
        e_gnt = (m_owner < 0) ? 2'b00 : (m_owner == 0 ? 2'b01 : 2'b10);
        e_s   = '0;
        if (busy)
            e_s = {cyc[m_owner], stb[m_owner], we[m_owner], adr[m_owner], dat[m_owner]};
        e_m0 = {busy && m_owner == 0 && s_ack, m_err && m_owner == 0, s_dat};
        e_m1 = {busy && m_owner == 1 && s_ack, m_err && m_owner == 1, s_dat};
        chk("gnt",   {30'd0, gnt_o}, {30'd0, e_gnt});
        chk("slave", {13'd0, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o}, {13'd0, e_s});
        chk("m0",    {22'd0, m0_ack_o, m0_err_o, m0_dat_o}, {22'd0, e_m0});
        chk("m1",    {22'd0, m1_ack_o, m1_err_o, m1_dat_o}, {22'd0, e_m1});
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check_outputs();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cyc = 2'b00; stb = 2'b00; we = 2'b00;
        adr[0] = 8'h00; adr[1] = 8'h00; dat[0] = 8'h00; dat[1] = 8'h00;
        s_ack = 1'b0; s_dat = 8'h00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int ack_mode;
        rst_n = 1'b0;
        idle_inputs();
        #2;
        chk("rst_gnt", {30'd0, gnt_o}, 32'd0);
        chk("rst_stb", {31'd0, s_stb_o}, 32'd0);
        chk("rst_ack", {30'd0, m0_ack_o, m1_ack_o}, 32'd0);
        do_reset();

        // single m0 read, slave acks on the third strobe cycle
        cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 8'h10;
        tick();
        chk("t1_gnt", {30'd0, gnt_o}, 32'h1);
        chk("t1_adr", {24'd0, s_adr_o}, 32'h10);
        tick();
        tick();
        s_ack = 1'b1; s_dat = 8'hA5;
        #1;
        chk("t1_ack",   {31'd0, m0_ack_o}, 32'h1);
        chk("t1_dat",   {24'd0, m0_dat_o}, 32'hA5);
        chk("t1_m1ack", {31'd0, m1_ack_o}, 32'h0);
        tick();
        idle_inputs();
        tick();

        // simultaneous request after reset, zero-idle handover
        do_reset();
        cyc = 2'b11; stb = 2'b11; adr[1] = 8'h20;
        tick();
        chk("t2_first", {30'd0, gnt_o}, 32'h1);
        s_ack = 1'b1;
        #1;
        chk("t2_ack0", {30'd0, m1_ack_o, m0_ack_o}, 32'h1);
        tick();
        s_ack = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
        tick();
        chk("t2_handover", {30'd0, gnt_o}, 32'h2);
        s_ack = 1'b1;
        #1;
        chk("t2_ack1", {30'd0, m1_ack_o, m0_ack_o}, 32'h2);
        tick();
        s_ack = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
        tick();
        chk("t2_idle", {30'd0, gnt_o}, 32'h0);

        // m0 releases and re-requests at once while m1 waits
        do_reset();
        cyc = 2'b11; stb = 2'b11;
        tick();
        chk("t3_first", {30'd0, gnt_o}, 32'h1);
        cyc[0] = 1'b0; stb[0] = 1'b0;
        tick();
        chk("t3_m1", {30'd0, gnt_o}, 32'h2);
        cyc[0] = 1'b1; stb[0] = 1'b1;
        tick();
        chk("t3_hold", {30'd0, gnt_o}, 32'h2);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        tick();
        chk("t3_back", {30'd0, gnt_o}, 32'h1);
        idle_inputs();
        tick();

        // m1 write, slave never acks
        do_reset();
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 8'h3F; dat[1] = 8'h5A;
        tick();
        for (int k = 1; k <= 20; k++) begin
            chk("t4_err", {31'd0, m1_err_o}, {31'd0, k == 16});
            chk("t4_gnt", {30'd0, gnt_o}, 32'h2);
            if (k == 16) begin
                chk("t4_stb_err", {30'd0, s_cyc_o, s_stb_o}, 32'h0);
            end else begin
                chk("t4_req", {14'd0, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o},
                    {14'd0, 3'b111, 8'h3F, 8'h5A});
            end
            tick();
        end
        idle_inputs();
        tick();

        // ack on the TIMEOUT-th strobe cycle beats the watchdog
        do_reset();
        cyc[0] = 1'b1; stb[0] = 1'b1;
        tick();
        for (int k = 1; k <= 17; k++) begin
            s_ack = (k == TO);
            #1;
            chk("t5_err", {31'd0, m0_err_o}, 32'h0);
            chk("t5_ack", {31'd0, m0_ack_o}, {31'd0, k == TO});
            tick();
        end
        idle_inputs();
        tick();

        // async reset mid-transfer with m0 owning the bus
        do_reset();
        cyc[0] = 1'b1; stb[0] = 1'b1;
        tick();
        cyc[1] = 1'b1; stb[1] = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_stb", {31'd0, s_stb_o}, 32'h0);
        chk("t6_gnt", {30'd0, gnt_o}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_tie", {30'd0, gnt_o}, 32'h1);
        idle_inputs();
        tick();

        // randomized traffic
        do_reset();
        ack_mode = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 64 == 0) ack_mode = $urandom_range(0, 2);
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 15) == 0) cyc[i] = ~cyc[i];
                stb[i] = cyc[i] && ($urandom_range(0, 15) != 0);
                we[i]  = $urandom_range(0, 1);
                adr[i] = 8'($urandom);
                dat[i] = 8'($urandom);
            end
            s_dat = 8'($urandom);
            s_ack = (ack_mode != 0) && ($urandom_range(0, 2) == 0);
            tick();
        end

        idle_inputs();
        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_gumnut_bus_arbiter
